// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flow controller.
package hazard_ctrl_pkg;

  // Flow-control FSM states
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrlState_t;

  // Accumulator write-select code meaning "no write"
  localparam int unsigned SEL_NONE = 0;

  // Depth of the per-accumulator pending-write shift register (EX, ME, WB)
  localparam int unsigned PEND_W = 3;

  // Stage positions inside the pending-write shift register
  localparam logic [1:0] STG_EX = 2'd0;
  localparam logic [1:0] STG_ME = 2'd1;
  localparam logic [1:0] STG_WB = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder-side bundle between the ID stage and the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 16
);

  logic [SEL_W-1:0] iSelA;
  logic [SEL_W-1:0] iSelB;
  logic             iReadA;
  logic             iReadB;
  logic             iFlagA;
  logic             iFlagB;
  logic             iJmpEnable;
  logic             iBranchEnable;
  logic             oPcEnable;
  logic             oIfIdEnable;
  logic             oBubble;
  logic             oFlush;
  logic [CNT_W-1:0] oStallCount;

  // Decoder / pipeline side
  modport master (
    output iSelA, iSelB, iReadA, iReadB, iFlagA, iFlagB,
    output iJmpEnable, iBranchEnable,
    input  oPcEnable, oIfIdEnable, oBubble, oFlush, oStallCount
  );

  // Hazard controller side
  modport slave (
    input  iSelA, iSelB, iReadA, iReadB, iFlagA, iFlagB,
    input  iJmpEnable, iBranchEnable,
    output oPcEnable, oIfIdEnable, oBubble, oFlush, oStallCount
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-write tracker for one accumulator: a write issued from ID walks
// through EX, ME and WB; readers and flag tests are checked against it.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iIssue,
  input  logic [SEL_W-1:0] iSel,
  input  logic             iRead,
  input  logic             iFlag,
  output logic             oDataHazard,
  output logic             oFlagHazard
);

  logic [PEND_W-1:0] pend;

  // Advance in-flight writes one stage per cycle; enter EX only on a real issue
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend <= '0;
    end else begin
      pend[STG_WB] <= pend[STG_ME];
      pend[STG_ME] <= pend[STG_EX];
      pend[STG_EX] <= iIssue & (iSel != SEL_W'(SEL_NONE));
    end
  end

  // Operand reads are safe once the producer is in WB (written before the
  // consumer's EX); flags only become valid after the writeback edge.
  always_comb begin
    oDataHazard = iRead & (pend[STG_EX] | pend[STG_ME]);
    oFlagHazard = iFlag & (|pend);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flow controller for the 8-bit accumulator processor.
// Stalls IF/ID with a bubble into ID/EX on RAW hazards and squashes the
// wrong-path fetch slots after a taken jump or branch.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic         Clock,
  input logic         Reset,
  hazard_ctrl_if.slave bus
);

  // A zero flush length still squashes one slot; the FSM needs at least one cycle
  localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;
  localparam int unsigned FC_W       = $clog2(FLUSH_LOAD + 1);

  ctrlState_t       state;
  logic [FC_W-1:0]  flushCnt;
  logic [CNT_W-1:0] stallCount;

  logic dataHazA;
  logic dataHazB;
  logic flagHazA;
  logic flagHazB;
  logic flushing;
  logic stall;
  logic issue;
  logic redirect;

  hazard_scoreboard #(
    .SEL_W (SEL_W)
  ) u_sbA (
    .Clock       (Clock),
    .Reset       (Reset),
    .iIssue      (issue),
    .iSel        (bus.iSelA),
    .iRead       (bus.iReadA),
    .iFlag       (bus.iFlagA),
    .oDataHazard (dataHazA),
    .oFlagHazard (flagHazA)
  );

  hazard_scoreboard #(
    .SEL_W (SEL_W)
  ) u_sbB (
    .Clock       (Clock),
    .Reset       (Reset),
    .iIssue      (issue),
    .iSel        (bus.iSelB),
    .iRead       (bus.iReadB),
    .iFlag       (bus.iFlagB),
    .oDataHazard (dataHazB),
    .oFlagHazard (flagHazB)
  );

  // Hazard, issue and redirect decisions; a squashed slot never stalls or redirects
  always_comb begin
    flushing = (state == FLUSH);
    stall    = (dataHazA | dataHazB | flagHazA | flagHazB) & ~flushing;
    issue    = ~stall & ~flushing;
    redirect = (bus.iJmpEnable | bus.iBranchEnable) & issue;
  end

  // RUN/FLUSH sequencing with the squash-slot counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= RUN;
      flushCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            state    <= FLUSH;
            flushCnt <= FC_W'(FLUSH_LOAD);
          end
        end
        FLUSH: begin
          flushCnt <= flushCnt - FC_W'(1);
          if (flushCnt <= FC_W'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state    <= RUN;
          flushCnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of hazard-stall cycles
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

  // Pipeline control, same-cycle from registered state and current decode
  always_comb begin
    bus.oPcEnable   = 1'b1;
    bus.oIfIdEnable = 1'b1;
    bus.oBubble     = 1'b0;
    bus.oFlush      = 1'b0;
    if (Reset) begin
      bus.oBubble = 1'b1;
    end else if (flushing) begin
      bus.oFlush  = 1'b1;
      bus.oBubble = 1'b1;
    end else if (stall) begin
      bus.oPcEnable   = 1'b0;
      bus.oIfIdEnable = 1'b0;
      bus.oBubble     = 1'b1;
    end
  end

  assign bus.oStallCount = stallCount;

endmodule
